slavefifo2b_stream_in_writer: RTL and testbench
===============================================

Name: slavefifo2b_stream_in_writer

Overview:
- Stream-IN master for the FX3 Slave FIFO 2-bit-address interface. It moves 32-bit words from an internal valid/ready source into the FX3 IN thread.
- Drives SLWR#, PKTEND# and the data bus, and honours FX3 FLAGA (thread ready) and FLAGB (watermark).
- Commits short packets on source-idle timeout or on mode exit.
- Sits beside the stream-OUT reader; the top-level mux selects between them by mode.

Parameters:
- PKT_WORDS, 1024, words per FX3 DMA buffer; a full buffer auto-commits with no PKTEND.
- IDLE_TIMEOUT, 64, consecutive WRITE cycles with no accepted word before a partial packet is committed.
- FLAG_LATENCY, 3, cycles held in WR_DELAY after FLAGB deasserts, covering FX3 flag latency and the buffer switch.

Ports:
- clk_100  in  1  100 MHz interface clock.
- reset_  in  1  asynchronous active-low reset.
- stream_in_mode_selected  in  1  stream-IN mode enable.
- flaga_d  in  1  registered FLAGA; 1 = IN thread ready.
- flagb_d  in  1  registered FLAGB watermark; 1 = room above watermark.
- src_valid  in  1  source word valid.
- src_data  in  32  source word.
- src_ready  out  1  block accepts a word this cycle (combinational).
- slwr_streamIN_  out  1  SLWR#, active low, registered.
- pktend_streamIN_  out  1  PKTEND#, active low, registered.
- data_out  out  32  FX3 data bus value, registered.
- data_oe  out  1  FPGA drives the data bus, registered.
- writing  out  1  high while the state is WRITE.

Behaviour:
- Reset (async, reset_ low): state IDLE; slwr_streamIN_=1; pktend_streamIN_=1; data_out=0; data_oe=0; word_cnt=0; idle_cnt=0; dly_cnt=0. This forces src_ready=0 and writing=0.
- Reset asserted mid-write: outputs go inactive immediately; no PKTEND is issued; any partial packet is abandoned.
- States: IDLE, FLAGA_RCVD, WAIT_FLAGB, WRITE, WR_DELAY, PKTEND.
- IDLE -> FLAGA_RCVD when stream_in_mode_selected & flaga_d.
- FLAGA_RCVD -> WAIT_FLAGB unconditionally (one flag-settle cycle).
- WAIT_FLAGB -> WRITE when flagb_d=1.
  - Leaves to IDLE if mode drops while waiting.
- WRITE, transitions in priority order:
  1. flagb_d=0 -> WR_DELAY.
  2. !stream_in_mode_selected -> PKTEND if word_cnt!=0, else IDLE.
  3. idle_cnt==IDLE_TIMEOUT-1 and no accept this cycle and word_cnt!=0 -> PKTEND.
  4. Otherwise stay in WRITE.
- WR_DELAY: dly_cnt loads FLAG_LATENCY-1 on entry and decrements each cycle; at 0 -> IDLE. word_cnt is preserved.
- PKTEND: lasts exactly one cycle, then IDLE; word_cnt and idle_cnt clear.
- src_ready = (state==WRITE) & flagb_d & stream_in_mode_selected. A word is never accepted in the cycle of a flagb drop or mode drop.
- Accept (src_valid & src_ready): on the next edge slwr_streamIN_<=0 and data_out<=src_data. Latency is one cycle; one SLWR# pulse per accepted word. With no accept, slwr_streamIN_<=1 and data_out holds its value.
- pktend_streamIN_<=0 on the edge entering PKTEND and 1 otherwise. In that cycle slwr_streamIN_ is 1, so this is a zero-data commit of the words already written.
- word_cnt: +1 per accept; wraps to 0 after PKT_WORDS-1; width clog2(PKT_WORDS).
- idle_cnt: clears on accept or on leaving WRITE; otherwise increments in WRITE, saturating at IDLE_TIMEOUT-1.
- Timeout applies only when word_cnt!=0. With word_cnt==0 the block stays in WRITE indefinitely.
- data_oe: set on the edge entering WRITE; cleared on the edge entering IDLE. It stays high through WR_DELAY and PKTEND.
- writing = (state==WRITE).

Test Plan:
- Reset, then mode=1, flaga=1, flagb=1, src_valid=1, src_data=0x1000+n -> src_ready rises in cycle 3 after flaga; each SLWR# low cycle carries data_out=0x1000,0x1001,...; no gaps.
- PKT_WORDS=8, stream 8 words continuously -> 8 SLWR# pulses; pktend never low; word_cnt=0 after the 8th.
- Stream 5 words, then src_valid=0 for IDLE_TIMEOUT cycles -> pktend low for exactly one cycle with slwr high, 64 cycles after the last accept; then IDLE; word_cnt=0.
- flagb drops while src_valid=1 -> src_ready=0 in the same cycle; slwr high from the next edge; WR_DELAY lasts 3 cycles, then IDLE; re-entry resumes with word_cnt preserved.
- Mode deasserted after 3 words -> PKTEND pulse, then IDLE, data_oe=0. Mode deasserted with word_cnt=0 -> direct IDLE, no pktend.
- reset_ pulsed low mid-stream -> slwr, pktend and data_oe inactive asynchronously; restart streams from word_cnt=0.

Source files
------------

// File: rtl/slavefifo2b_stream_in_writer_if.sv
// Source-side word stream feeding the FX3 stream-IN writer.
// A word transfers on a clock edge where src_valid and src_ready are both high;
// src_data must be stable while src_valid is high, and src_ready may depend combinationally on state and flags.
interface slavefifo2b_stream_in_writer_if;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;

  modport master (output src_valid, output src_data, input src_ready);
  modport slave  (input src_valid, input src_data, output src_ready);
endinterface

// File: rtl/slavefifo2b_stream_in_writer.sv
// FX3 Slave FIFO 2-bit stream-IN master: moves source words onto the FX3 bus with SLWR#,
// commits short packets with PKTEND# on source-idle timeout or mode exit.
module slavefifo2b_stream_in_writer #(
  parameter int PKT_WORDS    = 1024,
  parameter int IDLE_TIMEOUT = 64,
  parameter int FLAG_LATENCY = 3,
  localparam int WCW = $clog2(PKT_WORDS)
) (
  input  logic                clk_100,
  input  logic                reset_,
  input  logic                stream_in_mode_selected,
  input  logic                flaga_d,
  input  logic                flagb_d,
  slavefifo2b_stream_in_writer_if.slave src,
  output logic                slwr_streamIN_,
  output logic                pktend_streamIN_,
  output logic [31:0]         data_out,
  output logic                data_oe,
  output logic                writing,
  output logic [2:0]          state_dbg,
  output logic [WCW-1:0]      word_cnt_dbg
);

  localparam int ICW = $clog2(IDLE_TIMEOUT + 1);
  localparam int DCW = $clog2(FLAG_LATENCY + 1);
  localparam logic [WCW-1:0] WC_LAST  = WCW'(PKT_WORDS - 1);
  localparam logic [ICW-1:0] IC_LAST  = ICW'(IDLE_TIMEOUT - 1);
  localparam logic [DCW-1:0] DLY_LOAD = DCW'(FLAG_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FLAGA_RCVD = 3'd1,
    WAIT_FLAGB = 3'd2,
    WRITE      = 3'd3,
    WR_DELAY   = 3'd4,
    PKTEND     = 3'd5
  } state_t;

  state_t         state;
  logic [WCW-1:0] word_cnt;
  logic [ICW-1:0] idle_cnt;
  logic [DCW-1:0] dly_cnt;
  logic           accept;

  // Never accept in the cycle FLAGB or mode drops, so no word is written past the watermark.
  assign src.src_ready  = (state == WRITE) & flagb_d & stream_in_mode_selected;
  assign accept         = src.src_valid & src.src_ready;
  assign writing        = (state == WRITE);
  assign state_dbg      = state;
  assign word_cnt_dbg   = word_cnt;

  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      state            <= IDLE;
      slwr_streamIN_   <= 1'b1;
      pktend_streamIN_ <= 1'b1;
      data_out         <= '0;
      data_oe          <= 1'b0;
      word_cnt         <= '0;
      idle_cnt         <= '0;
      dly_cnt          <= '0;
    end else begin
      slwr_streamIN_   <= ~accept;
      pktend_streamIN_ <= 1'b1;
      if (accept) begin
        data_out <= src.src_data;
        word_cnt <= (word_cnt == WC_LAST) ? '0 : word_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (stream_in_mode_selected && flaga_d) state <= FLAGA_RCVD;
        end
        FLAGA_RCVD: state <= WAIT_FLAGB;
        WAIT_FLAGB: begin
          if (!stream_in_mode_selected) begin
            state <= IDLE;
          end else if (flagb_d) begin
            state    <= WRITE;
            data_oe  <= 1'b1;
            idle_cnt <= '0;
          end
        end
        WRITE: begin
          if (!flagb_d) begin
            state    <= WR_DELAY;
            dly_cnt  <= DLY_LOAD;
            idle_cnt <= '0;
          end else if (!stream_in_mode_selected) begin
            idle_cnt <= '0;
            if (word_cnt != '0) begin
              state            <= PKTEND;
              pktend_streamIN_ <= 1'b0;
            end else begin
              state   <= IDLE;
              data_oe <= 1'b0;
            end
          end else if (!accept && idle_cnt == IC_LAST && word_cnt != '0) begin
            state            <= PKTEND;
            pktend_streamIN_ <= 1'b0;
            idle_cnt         <= '0;
          end else if (accept) begin
            idle_cnt <= '0;
          end else if (idle_cnt != IC_LAST) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        WR_DELAY: begin
          // Partial packet stays open across the delay; word_cnt is kept.
          if (dly_cnt == '0) begin
            state   <= IDLE;
            data_oe <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        PKTEND: begin
          state    <= IDLE;
          data_oe  <= 1'b0;
          word_cnt <= '0;
          idle_cnt <= '0;
        end
        default: begin
          state   <= IDLE;
          data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slavefifo2b_stream_in_writer.sv
// Bench for the FX3 stream-IN writer: vector table for start-up and a short packet,
// then directed sequences for full buffer, idle timeout, FLAGB drop, mode exit and async reset.
module tb_slavefifo2b_stream_in_writer;

  logic        clk_100 = 1'b0;
  logic        reset_;
  logic        stream_in_mode_selected;
  logic        flaga_d;
  logic        flagb_d;
  logic        slwr_streamIN_;
  logic        pktend_streamIN_;
  logic [31:0] data_out;
  logic        data_oe;
  logic        writing;
  logic [2:0]  state_dbg;
  logic [2:0]  word_cnt_dbg;

  slavefifo2b_stream_in_writer_if src_if();

  slavefifo2b_stream_in_writer #(
    .PKT_WORDS(8),
    .IDLE_TIMEOUT(64),
    .FLAG_LATENCY(3)
  ) dut (
    .clk_100                 (clk_100),
    .reset_                  (reset_),
    .stream_in_mode_selected (stream_in_mode_selected),
    .flaga_d                 (flaga_d),
    .flagb_d                 (flagb_d),
    .src                     (src_if),
    .slwr_streamIN_          (slwr_streamIN_),
    .pktend_streamIN_        (pktend_streamIN_),
    .data_out                (data_out),
    .data_oe                 (data_oe),
    .writing                 (writing),
    .state_dbg               (state_dbg),
    .word_cnt_dbg            (word_cnt_dbg)
  );

  // clock / reset
  always #5 clk_100 = ~clk_100;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int n_slwr = 0;
  int n_pkt  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  in_bits;   // mode, flaga, flagb, src_valid
    logic [31:0] d;
    logic [4:0]  exp_bits;  // src_ready, slwr#, pktend#, data_oe, writing
    logic [31:0] dout;
    logic [2:0]  st;
    logic [2:0]  wc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one cycle of stimulus, scoreboard pop on SLWR#, ready check, push on expected accept
  task automatic cyc(input logic [3:0] in_bits, input logic [31:0] d, input logic exp_rdy);
    @(negedge clk_100);
    stream_in_mode_selected = in_bits[3];
    flaga_d                 = in_bits[2];
    flagb_d                 = in_bits[1];
    src_if.src_valid        = in_bits[0];
    src_if.src_data         = d;
    #1;
    if (slwr_streamIN_ === 1'b0) begin
      n_slwr++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: SLWR# low with data %h but no word expected", data_out);
      end else begin
        chk("sb_data", data_out, exp_q.pop_front());
      end
    end
    if (pktend_streamIN_ === 1'b0) n_pkt++;
    chk("src_ready", 32'(src_if.src_ready), 32'(exp_rdy));
    if (in_bits[0] && exp_rdy) exp_q.push_back(d);
  endtask

  // IDLE -> FLAGA_RCVD -> WAIT_FLAGB -> WRITE takes three edges
  task automatic enter_write();
    for (int i = 0; i < 3; i++) cyc(4'b1110, 32'h0, 1'b0);
  endtask

  initial begin
    int gap, dly, s0, p0;

    vecs[0]  = '{4'b0000, 32'h0,    5'b01100, 32'h0,    3'd0, 3'd0};
    vecs[1]  = '{4'b1111, 32'h1000, 5'b01100, 32'h0,    3'd0, 3'd0};
    vecs[2]  = '{4'b1111, 32'h1000, 5'b01100, 32'h0,    3'd1, 3'd0};
    vecs[3]  = '{4'b1111, 32'h1000, 5'b01100, 32'h0,    3'd2, 3'd0};
    vecs[4]  = '{4'b1111, 32'h1000, 5'b11111, 32'h0,    3'd3, 3'd0};
    vecs[5]  = '{4'b1111, 32'h1001, 5'b10111, 32'h1000, 3'd3, 3'd1};
    vecs[6]  = '{4'b1111, 32'h1002, 5'b10111, 32'h1001, 3'd3, 3'd2};
    vecs[7]  = '{4'b1110, 32'h1003, 5'b10111, 32'h1002, 3'd3, 3'd3};
    vecs[8]  = '{4'b1110, 32'h1003, 5'b11111, 32'h1002, 3'd3, 3'd3};
    vecs[9]  = '{4'b1111, 32'h1003, 5'b11111, 32'h1002, 3'd3, 3'd3};
    vecs[10] = '{4'b1110, 32'h1004, 5'b10111, 32'h1003, 3'd3, 3'd4};
    vecs[11] = '{4'b0011, 32'h1004, 5'b01111, 32'h1003, 3'd3, 3'd4};
    vecs[12] = '{4'b0010, 32'h0,    5'b01010, 32'h1003, 3'd5, 3'd4};
    vecs[13] = '{4'b0000, 32'h0,    5'b01100, 32'h1003, 3'd0, 3'd0};

    reset_ = 1'b0;
    stream_in_mode_selected = 1'b0;
    flaga_d = 1'b0;
    flagb_d = 1'b0;
    src_if.src_valid = 1'b0;
    src_if.src_data = 32'h0;
    @(negedge clk_100);
    @(negedge clk_100);
    #1;
    chk("rst_slwr",   32'(slwr_streamIN_),   32'd1);
    chk("rst_pktend", 32'(pktend_streamIN_), 32'd1);
    chk("rst_data",   data_out,              32'h0);
    chk("rst_oe",     32'(data_oe),          32'd0);
    chk("rst_writing",32'(writing),          32'd0);
    chk("rst_ready",  32'(src_if.src_ready), 32'd0);
    chk("rst_state",  32'(state_dbg),        32'd0);
    chk("rst_wc",     32'(word_cnt_dbg),     32'd0);
    reset_ = 1'b1;

    // start-up latency, gapless stream, idle gap, mode exit with 4 words -> PKTEND
    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].in_bits, vecs[i].d, vecs[i].exp_bits[4]);
      chk($sformatf("vec%0d_slwr", i),    32'(slwr_streamIN_),   32'(vecs[i].exp_bits[3]));
      chk($sformatf("vec%0d_pktend", i),  32'(pktend_streamIN_), 32'(vecs[i].exp_bits[2]));
      chk($sformatf("vec%0d_oe", i),      32'(data_oe),          32'(vecs[i].exp_bits[1]));
      chk($sformatf("vec%0d_writing", i), 32'(writing),          32'(vecs[i].exp_bits[0]));
      chk($sformatf("vec%0d_data", i),    data_out,              vecs[i].dout);
      chk($sformatf("vec%0d_state", i),   32'(state_dbg),        32'(vecs[i].st));
      chk($sformatf("vec%0d_wc", i),      32'(word_cnt_dbg),     32'(vecs[i].wc));
    end

    // full buffer of 8 words: auto-commit, no PKTEND, no timeout with word_cnt==0
    s0 = n_slwr;
    p0 = n_pkt;
    enter_write();
    for (int n = 0; n < 8; n++) cyc(4'b1011, 32'h2000 + 32'(n), 1'b1);
    for (int n = 0; n < 4; n++) cyc(4'b1010, 32'h0, 1'b1);
    chk("full_pulses", 32'(n_slwr - s0), 32'd8);
    chk("full_wc",     32'(word_cnt_dbg), 32'd0);
    for (int n = 0; n < 70; n++) cyc(4'b1010, 32'h0, 1'b1);
    chk("full_no_timeout_state", 32'(state_dbg), 32'd3);
    chk("full_no_pktend",        32'(n_pkt - p0), 32'd0);
    cyc(4'b0010, 32'h0, 1'b0);
    cyc(4'b0010, 32'h0, 1'b0);
    chk("exit_wc0_state",  32'(state_dbg), 32'd0);
    chk("exit_wc0_oe",     32'(data_oe),   32'd0);
    chk("exit_wc0_pktend", 32'(n_pkt - p0), 32'd0);

    // 5 words then source idle: PKTEND 64 cycles after the last SLWR# pulse
    p0 = n_pkt;
    enter_write();
    for (int n = 0; n < 5; n++) cyc(4'b1011, 32'h3000 + 32'(n), 1'b1);
    cyc(4'b1010, 32'h0, 1'b1);
    gap = 0;
    while (gap < 100) begin
      cyc(4'b1010, 32'h0, (gap + 1 < 64));
      gap++;
      if (pktend_streamIN_ === 1'b0) break;
    end
    chk("timeout_gap",   32'(gap),            32'd64);
    chk("timeout_slwr",  32'(slwr_streamIN_), 32'd1);
    chk("timeout_state", 32'(state_dbg),      32'd5);
    cyc(4'b1010, 32'h0, 1'b0);
    chk("timeout_idle",   32'(state_dbg),        32'd0);
    chk("timeout_oe",     32'(data_oe),          32'd0);
    chk("timeout_wc",     32'(word_cnt_dbg),     32'd0);
    chk("timeout_pkt_hi", 32'(pktend_streamIN_), 32'd1);
    chk("timeout_pulses", 32'(n_pkt - p0),       32'd1);

    // FLAGB drop after 3 words: WR_DELAY for 3 cycles, word_cnt kept, resume wraps at 8
    p0 = n_pkt;
    enter_write();
    for (int n = 0; n < 3; n++) cyc(4'b1011, 32'h4000 + 32'(n), 1'b1);
    cyc(4'b1001, 32'h4003, 1'b0);
    chk("flagb_drop_state", 32'(state_dbg), 32'd3);
    dly = 0;
    for (int n = 0; n < 10; n++) begin
      cyc(4'b1000, 32'h0, 1'b0);
      if (n == 0) begin
        chk("wrdelay_slwr", 32'(slwr_streamIN_), 32'd1);
        chk("wrdelay_oe",   32'(data_oe),        32'd1);
      end
      if (state_dbg != 3'd4) break;
      dly++;
    end
    chk("wrdelay_len",   32'(dly),          32'd3);
    chk("wrdelay_idle",  32'(state_dbg),    32'd0);
    chk("wrdelay_oe_lo", 32'(data_oe),      32'd0);
    chk("wrdelay_wc",    32'(word_cnt_dbg), 32'd3);
    enter_write();
    for (int n = 0; n < 5; n++) cyc(4'b1011, 32'h4003 + 32'(n), 1'b1);
    cyc(4'b1010, 32'h0, 1'b1);
    chk("resume_wrap_wc", 32'(word_cnt_dbg), 32'd0);
    chk("resume_state",   32'(state_dbg),    32'd3);
    chk("resume_no_pkt",  32'(n_pkt - p0),   32'd0);
    cyc(4'b0010, 32'h0, 1'b0);
    cyc(4'b0010, 32'h0, 1'b0);
    chk("resume_exit_idle", 32'(state_dbg), 32'd0);

    // async reset mid-stream: outputs drop at once, partial packet abandoned
    p0 = n_pkt;
    enter_write();
    for (int n = 0; n < 3; n++) cyc(4'b1011, 32'h5000 + 32'(n), 1'b1);
    cyc(4'b1011, 32'h5003, 1'b1);
    chk("pre_rst_slwr", 32'(slwr_streamIN_), 32'd0);
    #2;
    reset_ = 1'b0;
    #1;
    chk("async_slwr",   32'(slwr_streamIN_),   32'd1);
    chk("async_pktend", 32'(pktend_streamIN_), 32'd1);
    chk("async_oe",     32'(data_oe),          32'd0);
    chk("async_ready",  32'(src_if.src_ready), 32'd0);
    chk("async_state",  32'(state_dbg),        32'd0);
    chk("async_wc",     32'(word_cnt_dbg),     32'd0);
    exp_q.delete();
    stream_in_mode_selected = 1'b0;
    src_if.src_valid = 1'b0;
    @(negedge clk_100);
    @(negedge clk_100);
    #1;
    reset_ = 1'b1;
    enter_write();
    for (int n = 0; n < 2; n++) cyc(4'b1011, 32'h6000 + 32'(n), 1'b1);
    cyc(4'b1010, 32'h0, 1'b1);
    chk("restart_wc", 32'(word_cnt_dbg), 32'd2);
    cyc(4'b0010, 32'h0, 1'b0);
    cyc(4'b0010, 32'h0, 1'b0);
    chk("restart_pktend_state", 32'(state_dbg), 32'd5);
    cyc(4'b0010, 32'h0, 1'b0);
    chk("restart_idle",    32'(state_dbg),  32'd0);
    chk("restart_pkt_cnt", 32'(n_pkt - p0), 32'd1);
    chk("sb_empty",        32'(exp_q.size()), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
